pvt_link_master: RTL and testbench
==================================

# pvt_link_master

On-chip host-side initiator for the PVT sensor serial command link. It takes a parallel command, serializes it onto `tx` as a header frame plus 0–4 payload frames, and, for read commands, captures one response frame from `rx`. It sits between the system controller or register bank and the sensor wrapper's serial port. This replaces the bench-driven stimulus with synthesizable logic.

## Interface
- `CLKS_PER_BIT`, 1: clock cycles per serial bit (≥1).
- `READ_TYPE`, 3'd2: header type code that triggers response capture.
- `TIMEOUT_CYCLES`, 256: maximum cycles to wait for a response start bit (≥1).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high in IDLE only; command accepted when `cmd_valid && cmd_ready`.
- `cmd_type`  in  3  header bits [7:5].
- `cmd_addr`  in  5  header bits [4:0].
- `cmd_len`  in  3  payload byte count; values >4 are clamped to 4.
- `cmd_data`  in  32  payload, right-aligned; the last byte sent is `cmd_data[7:0]`.
- `cmd_done`  out  1  one-cycle pulse when a command completes.
- `rsp_data`  out  8  response byte, valid with `cmd_done` on reads; otherwise 0.
- `rsp_err`  out  1  with `cmd_done`: the response stop bit was sampled low.
- `rsp_timeout`  out  1  with `cmd_done`: no start bit arrived within `TIMEOUT_CYCLES`.
- `tx`  out  1  serial out to the sensor wrapper `rx`; idles high.
- `rx`  in  1  serial in from the sensor wrapper `tx`.

## Operation
- Frame format: start bit (0), 8 data bits sent MSB first, stop bit (1). Each bit lasts `CLKS_PER_BIT` cycles.
- Command inputs are latched on accept and are ignored until `cmd_ready` returns high.
- States:
  - **IDLE**: `tx=1`, `cmd_ready=1`.
  - **TX_FRAME**: sends the header `{cmd_type,cmd_addr}`, then the payload bytes `cmd_data[8*len-1 -: 8]` down to `[7:0]`. Frames go out back-to-back with no idle bits between them.
  - **RX_WAIT**: entered after the last stop bit if `cmd_type==READ_TYPE`; otherwise the block goes to DONE.
  - **RX_FRAME**: captures the response byte.
  - **DONE**: lasts one cycle, asserts `cmd_done`, then returns to IDLE.
- `rx` passes through a 2-flop synchronizer that resets to 1. The synchronized value is written `rxs`.
- In RX_WAIT, the first cycle with `rxs==0` is the start cycle t0.
  - Data bit k (k=0..7, MSB first) is sampled at t0 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled at k=8. A stop bit of 0 sets `rsp_err=1`, and the captured byte is still reported.
- Timeout counter: cleared on entering RX_WAIT, increments each cycle. On reaching `TIMEOUT_CYCLES` the block goes to DONE with `rsp_timeout=1` and `rsp_data=0`.
- `rxs` is ignored outside RX_WAIT and RX_FRAME.
- `rsp_*` outputs hold their value until the next `cmd_done`.
- Reset values: `tx=1`, `cmd_ready=1`, `cmd_done=0`, `rsp_data=0`, `rsp_err=0`, `rsp_timeout=0`, state IDLE, counters 0.
- Reset mid-operation:
  - `tx` returns to 1 on the next edge.
  - The in-flight command is dropped with no `cmd_done`.
  - The synchronizer is reloaded with 1s.

## Timing
- Accept at edge c: `tx` drives the header start bit from cycle c+1.
- Write with len L: `tx` is active for (1+L)·10·`CLKS_PER_BIT` cycles. `cmd_done` pulses in the cycle after the last stop bit ends, and `cmd_ready` rises one cycle after that.
  - `CLKS_PER_BIT=1`, L=1: start bit in cycle c+1, `cmd_done` in c+21, `cmd_ready` in c+22.
- Read: `cmd_done` comes 1 cycle after the stop-bit sample, or in the cycle the timeout is reached.
- Latency from `rx` falling to start detection is 2 cycles (synchronizer).
- `cmd_valid` during busy is ignored. Nothing is queued.
- `cmd_len=0`: header frame only.

## Test plan
- Reset for 5 cycles, then release -> `tx=1`, `cmd_ready=1`, `cmd_done=0`, `rsp_*=0`.
- Write type 0, addr 0, len 1, data 0x01, `CLKS_PER_BIT=1` -> `tx` bit stream 0,00000000,1,0,00000001,1; `cmd_done` at c+21.
- Write type 0, addr 0, len 4, data 0x10101010 -> frames 0x00,0x10,0x10,0x10,0x10 sent back-to-back (50 cycles); `cmd_done` at c+51, `rsp_err=0`.
- Read type 2, addr 0, len 0 -> header 0x40 sent. Bench replies with a frame of 0xA5 5 cycles after the stop bit -> `cmd_done` with `rsp_data=0xA5`, `rsp_err=0`, `rsp_timeout=0`.
- Read with a silent `rx`, `TIMEOUT_CYCLES=256` -> `cmd_done` 256 cycles after entering RX_WAIT, `rsp_timeout=1`, `rsp_data=0`. A reply of 0x3C with stop bit 0 -> `rsp_data=0x3C`, `rsp_err=1`.
- Assert `rst` during payload bit 3 of a len-4 write -> `tx=1` next cycle, no `cmd_done`, `cmd_ready=1`. A new command then runs normally.

Source files
------------

// File: rtl/pvt_link_master.sv
// pvt_link_master: serializes a command header plus 0-4 payload frames on tx and, for reads, captures one response frame from rx
module pvt_link_master #(
  parameter int CLKS_PER_BIT = 1,
  parameter logic [2:0] READ_TYPE = 3'd2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [2:0] cmd_type,
  input  logic [4:0] cmd_addr,
  input  logic [2:0] cmd_len,
  input  logic [31:0] cmd_data,
  output logic cmd_done,
  output logic [7:0] rsp_data,
  output logic rsp_err,
  output logic rsp_timeout,
  output logic tx,
  input  logic rx
);
  localparam int CW = $clog2(CLKS_PER_BIT + CLKS_PER_BIT / 2 + 1) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, TX_FRAME, RX_WAIT, RX_FRAME, DONE} state_t;
  state_t state;
  logic [CW-1:0] ccnt;
  logic [TW-1:0] tcnt;
  logic [3:0] bit_idx;
  logic [2:0] frames_left, len_c;
  logic [39:0] sh;
  logic [31:0] data_c;
  logic [7:0] rsh;
  logic [1:0] sync;
  logic is_read, rxs;
  assign rxs = sync[1];
  assign len_c = cmd_len > 3'd4 ? 3'd4 : cmd_len;
  assign data_c = cmd_data << {3'd4 - len_c, 3'b000};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      cmd_ready <= 1'b1;
      cmd_done <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
      ccnt <= '0;
      tcnt <= '0;
      bit_idx <= '0;
      frames_left <= '0;
      sh <= '0;
      rsh <= '0;
      is_read <= 1'b0;
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
      cmd_done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          state <= TX_FRAME;
          cmd_ready <= 1'b0;
          tx <= 1'b0;
          sh <= {cmd_type, cmd_addr, data_c};
          frames_left <= len_c;
          is_read <= cmd_type == READ_TYPE;
          ccnt <= '0;
          bit_idx <= '0;
        end
        TX_FRAME: if (ccnt != CW'(CLKS_PER_BIT - 1)) ccnt <= ccnt + CW'(1);
        else begin
          ccnt <= '0;
          if (bit_idx == 4'd9) begin
            if (frames_left == 3'd0) begin
              tx <= 1'b1;
              tcnt <= '0;
              state <= is_read ? RX_WAIT : DONE;
              cmd_done <= !is_read;
              if (!is_read) begin
                rsp_data <= '0;
                rsp_err <= 1'b0;
                rsp_timeout <= 1'b0;
              end
            end else begin
              frames_left <= frames_left - 3'd1;
              sh <= sh << 8;
              bit_idx <= '0;
              tx <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx + 4'd1;
            // current byte sits in sh[39:32]; data bit b (1..8) of the frame is sh[40-b]
            tx <= bit_idx == 4'd8 ? 1'b1 : sh[6'd39 - {2'b00, bit_idx}];
          end
        end
        RX_WAIT: if (!rxs) begin
          state <= RX_FRAME;
          // first sample lands half a bit into data bit 0, measured from the start cycle
          ccnt <= CW'(CLKS_PER_BIT / 2 + CLKS_PER_BIT - 1);
          bit_idx <= '0;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= DONE;
          cmd_done <= 1'b1;
          rsp_data <= '0;
          rsp_err <= 1'b0;
          rsp_timeout <= 1'b1;
        end else tcnt <= tcnt + TW'(1);
        RX_FRAME: if (ccnt != '0) ccnt <= ccnt - CW'(1);
        else begin
          ccnt <= CW'(CLKS_PER_BIT - 1);
          if (bit_idx == 4'd8) begin
            state <= DONE;
            cmd_done <= 1'b1;
            rsp_data <= rsh;
            rsp_err <= !rxs;
            rsp_timeout <= 1'b0;
          end else begin
            rsh <= {rsh[6:0], rxs};
            bit_idx <= bit_idx + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pvt_link_master.sv
// tb_pvt_link_master: randomized self-checking bench for pvt_link_master against a frame-level reference model
module tb_pvt_link_master;
  localparam int CPB = 1;
  localparam int TMO = 256;
  localparam logic [2:0] RD = 3'd2;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rx = 1'b1;
  logic [2:0] cmd_type = '0, cmd_len = '0;
  logic [4:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic cmd_ready, cmd_done, rsp_err, rsp_timeout, tx;
  logic [7:0] rsp_data;
  int n_cmp = 0, n_mis = 0;
  pvt_link_master #(.CLKS_PER_BIT(CPB), .READ_TYPE(RD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .cmd_done(cmd_done), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .tx(tx), .rx(rx)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_cmd(input logic [2:0] t, input logic [4:0] a, input logic [2:0] ln, input logic [31:0] d,
                         input bit reply, input int dly, input logic [7:0] rb, input bit stop_ok);
    int L, w0, exp_done, done_n, p;
    logic [7:0] bytes [5];
    logic obs [50];
    logic [9:0] got10;
    bit rd;
    L = ln > 3'd4 ? 4 : int'(ln);
    bytes[0] = {t, a};
    for (int i = 0; i < L; i++) bytes[i+1] = 8'(d >> (8 * (L - 1 - i)));
    rd = t == RD;
    w0 = 10 * (1 + L) * CPB + 1;
    exp_done = !rd ? w0 : reply ? w0 + dly + 3 + CPB / 2 + 9 * CPB : w0 + TMO;
    for (int i = 0; i < 50; i++) obs[i] = 1'bx;
    @(negedge clk);
    check("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_type = t;
    cmd_addr = a;
    cmd_len = ln;
    cmd_data = d;
    done_n = 0;
    for (int n = 1; n <= 2000 && done_n == 0; n++) begin
      @(negedge clk);
      if (n == 1) check("ready_busy", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_type = 3'($urandom);
      cmd_addr = 5'($urandom);
      cmd_len = 3'($urandom);
      cmd_data = $urandom;
      if (n < w0 && (n - 1) % CPB == 0) obs[(n-1)/CPB] = tx;
      if (rd && reply && n >= w0 + dly) begin
        p = (n - w0 - dly) / CPB;
        rx = p == 0 ? 1'b0 : p <= 8 ? rb[8-p] : p == 9 ? stop_ok : 1'b1;
      end else rx = 1'b1;
      if (cmd_done) done_n = n;
    end
    cmd_valid = 1'b0;
    rx = 1'b1;
    check("done_cycle", 32'(done_n), 32'(exp_done));
    for (int f = 0; f <= L; f++) begin
      got10 = '0;
      for (int b = 0; b < 10; b++) got10 = {got10[8:0], obs[f*10+b]};
      check($sformatf("frame%0d", f), 32'(got10), 32'({1'b0, bytes[f], 1'b1}));
    end
    check("tx_idle_done", 32'(tx), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(rd && reply ? rb : 8'h00));
    check("rsp_err", 32'(rsp_err), 32'(rd && reply && !stop_ok));
    check("rsp_timeout", 32'(rsp_timeout), 32'(rd && !reply));
    @(negedge clk);
    check("done_pulse", 32'(cmd_done), 32'd0);
    check("ready_back", 32'(cmd_ready), 32'd1);
    check("rsp_hold", 32'(rsp_data), 32'(rd && reply ? rb : 8'h00));
  endtask
  initial begin
    int seen;
    logic [2:0] t;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(cmd_done), 32'd0);
    check("rst_rsp", 32'({rsp_data, rsp_err, rsp_timeout}), 32'd0);
    run_cmd(3'd0, 5'd0, 3'd1, 32'h0000_0001, 1'b0, 0, 8'h00, 1'b1);
    run_cmd(3'd0, 5'd0, 3'd4, 32'h1010_1010, 1'b0, 0, 8'h00, 1'b1);
    run_cmd(3'd2, 5'd0, 3'd0, 32'h0, 1'b1, 4, 8'hA5, 1'b1);
    run_cmd(3'd2, 5'd0, 3'd0, 32'h0, 1'b0, 0, 8'h00, 1'b1);
    run_cmd(3'd2, 5'd7, 3'd2, 32'hDEAD_BEEF, 1'b1, 3, 8'h3C, 1'b0);
    run_cmd(3'd5, 5'd31, 3'd0, 32'hFFFF_FFFF, 1'b0, 0, 8'h00, 1'b1);
    run_cmd(3'd1, 5'd9, 3'd7, 32'h1234_5678, 1'b0, 0, 8'h00, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type = 3'd0;
    cmd_addr = 5'd3;
    cmd_len = 3'd4;
    cmd_data = 32'hFFFF_FFFF;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_done", 32'(cmd_done), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (cmd_done || !tx) seen++;
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    run_cmd(3'd2, 5'd1, 3'd1, 32'h0000_0055, 1'b1, 0, 8'h81, 1'b1);
    for (int i = 0; i < 40; i++) begin
      t = 3'($urandom);
      if ($urandom_range(0, 9) < 4) t = RD;
      else if (t == RD) t = 3'd0;
      run_cmd(t, 5'($urandom), 3'($urandom), $urandom, $urandom_range(0, 5) != 0,
              int'($urandom_range(0, 30)), 8'($urandom), $urandom_range(0, 4) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
